// File: rtl/ins_prefetch.sv
`timescale 1ns/1ps
// ins_prefetch
//   Sequential instruction prefetch buffer. It sits between external
//   instruction memory and the core fetch port. It issues in-order,
//   pipelined word reads ahead of the core PC into a small FIFO, and it
//   serves hits combinationally. A non-sequential fetch address flushes
//   the FIFO and restarts prefetch there. Reads still in flight from
//   before the redirect are discarded when they return.
//
// Ports
//   clk          rising-edge clock
//   nrst         asynchronous active-low reset
//   exIns_ren    core requests the instruction at exIns_addr
//   exIns_addr   core fetch address (bits [1:0] ignored)
//   exIns_valid  exIns_in holds the instruction for exIns_addr this cycle
//   exIns_in     instruction word to the core
//   mem_req      read request to memory
//   mem_addr     word-aligned request address
//   mem_gnt      memory accepted the request this cycle
//   mem_rvalid   read data valid (responses return in request order)
//   mem_rdata    read data
module ins_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        exIns_ren,
    input  logic [31:0] exIns_addr,
    output logic        exIns_valid,
    output logic [31:0] exIns_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int OCC_W = $clog2(DEPTH + MAX_OUT + 1);

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      base_addr;
    logic [31:0]      pf_addr;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop;

    logic [31:0]      req_addr;
    logic             flush;
    logic             fifo_nempty;
    logic             hit;
    logic             grant;
    logic             push;
    logic [OCC_W-1:0] occupancy;

    assign req_addr    = {exIns_addr[31:2], 2'b00};
    assign flush       = exIns_ren && (req_addr != base_addr);
    assign fifo_nempty = (count != '0);
    assign hit         = exIns_ren && !flush && fifo_nempty;

    // Reads that will be dropped do not take FIFO space, so they are
    // excluded from the occupancy that throttles new requests. This also
    // keeps the FIFO from overflowing: every read that can be pushed has
    // a slot reserved at the time it is issued.
    assign occupancy = OCC_W'(count) + OCC_W'(outstanding) - OCC_W'(drop);

    assign mem_req  = nrst && !flush
                   && (outstanding < OUT_W'(MAX_OUT))
                   && (occupancy < OCC_W'(DEPTH));
    assign mem_addr = pf_addr;
    assign grant    = mem_req && mem_gnt;

    // A response that returns in a flush cycle belongs to the old stream
    // and is discarded along with the rest of the in-flight reads.
    assign push = mem_rvalid && (drop == '0) && !flush;

    assign exIns_valid = hit;
    assign exIns_in    = fifo_nempty ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            base_addr   <= RESET_PC;
            pf_addr     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            base_addr   <= req_addr;
            pf_addr     <= req_addr;
            outstanding <= outstanding - OUT_W'(mem_rvalid);
            drop        <= outstanding - OUT_W'(mem_rvalid);
        end else begin
            if (grant) begin
                pf_addr <= pf_addr + 32'd4;
            end
            if (grant && !mem_rvalid) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!grant && mem_rvalid) begin
                outstanding <= outstanding - OUT_W'(1);
            end
            if (mem_rvalid && (drop != '0)) begin
                drop <= drop - OUT_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (hit) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                base_addr <= base_addr + 32'd4;
            end
            if (push && !hit) begin
                count <= count + CNT_W'(1);
            end else if (hit && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage holds data only. Occupancy is tracked by the pointers
    // and count above, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ins_prefetch.sv
`timescale 1ns/1ps
module tb_ins_prefetch;

    logic        clk = 1'b0;
    logic        nrst;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    ins_prefetch #(
        .DEPTH   (4),
        .MAX_OUT (2),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .exIns_ren  (exIns_ren),
        .exIns_addr (exIns_addr),
        .exIns_valid(exIns_valid),
        .exIns_in   (exIns_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_gnt    = 0;

    logic [31:0] pend_q [$];   // memory side: granted addresses awaiting response
    logic [31:0] sb_q   [$];   // expected instruction words, in delivery order
    logic [31:0] gnt_log[$];   // addresses granted since last clear
    logic [31:0] pc;

    logic        obs_valid;
    logic        obs_req;
    logic [31:0] obs_in;
    logic [31:0] obs_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Called just after a rising edge; inputs are driven,
    // outputs are sampled on the falling edge, then it waits for the next
    // rising edge. Memory data is always address + 1.
    task automatic step(input logic ren, input logic [31:0] a, input logic gnt, input logic rsp);
        logic [31:0] exp_word;
        exIns_ren  = ren;
        exIns_addr = a;
        mem_gnt    = gnt;
        if (rsp && pend_q.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_q.pop_front() + 32'd1;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        @(negedge clk);
        obs_valid = exIns_valid;
        obs_in    = exIns_in;
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        if (obs_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_valid", {31'b0, obs_valid}, 32'h0);
            end else begin
                exp_word = sb_q.pop_front();
                check("sb_word", obs_in, exp_word);
            end
        end
        if (obs_req && gnt) begin
            pend_q.push_back(obs_addr);
            gnt_log.push_back(obs_addr);
            n_gnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_core(input int n, input int budget, input string tag);
        int hits = 0;
        for (int i = 0; i < budget && hits < n; i++) begin
            step(1'b1, pc, 1'b1, 1'b1);
            if (obs_valid) begin
                pc = pc + 32'd4;
                hits++;
            end
        end
        check({tag, "_hits"}, hits, n);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        nrst       = 1'b0;
        exIns_ren  = 1'b0;
        exIns_addr = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        pend_q.delete();
        sb_q.delete();
        gnt_log.delete();
        n_gnt = 0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values observed while nrst is held low
        nrst       = 1'b0;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid",    {31'b0, exIns_valid}, 32'h0);
        check("rst_req",      {31'b0, mem_req},     32'h0);
        check("rst_ins_in",   exIns_in,             32'h0);
        check("rst_mem_addr", mem_addr,             32'h0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Streaming from reset: back-to-back requests, first hit in cycle 2
        for (int k = 0; k < 9; k++) sb_q.push_back(32'(4 * k + 1));
        step(1'b1, 32'h0, 1'b1, 1'b1);
        check("t1_c0_req",   {31'b0, obs_req},   32'h1);
        check("t1_c0_addr",  obs_addr,           32'h0);
        check("t1_c0_valid", {31'b0, obs_valid}, 32'h0);
        step(1'b1, 32'h0, 1'b1, 1'b1);
        check("t1_c1_addr",  obs_addr,           32'h4);
        check("t1_c1_valid", {31'b0, obs_valid}, 32'h0);
        step(1'b1, 32'h0, 1'b1, 1'b1);
        check("t1_c2_valid", {31'b0, obs_valid}, 32'h1);
        check("t1_c2_addr",  obs_addr,           32'h8);
        pc = 32'h4;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, pc, 1'b1, 1'b1);
            check("t1_steady_valid", {31'b0, obs_valid}, 32'h1);
            pc = pc + 32'd4;
        end
        check("t1_sb_empty", sb_q.size(), 0);

        // Idle core: prefetch stops once FIFO + in-flight reaches DEPTH
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("t2_ngnt",     n_gnt,            4);
        check("t2_req_low",  {31'b0, obs_req}, 32'h0);
        check("t2_last_gnt", gnt_log[3],       32'hC);
        for (int k = 0; k < 4; k++) sb_q.push_back(32'(4 * k + 1));
        pc = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, pc, 1'b1, 1'b1);
            check("t2_hit_valid", {31'b0, obs_valid}, 32'h1);
            pc = pc + 32'd4;
        end
        check("t2_sb_empty", sb_q.size(), 0);

        // Redirect with two reads outstanding; both old responses dropped
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("t3_gnt4", obs_addr, 32'h4);
        step(1'b1, 32'h100, 1'b1, 1'b0);
        check("t3_flush_req",   {31'b0, obs_req},   32'h0);
        check("t3_flush_valid", {31'b0, obs_valid}, 32'h0);
        sb_q.push_back(32'h101);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        check("t3_a_req", {31'b0, obs_req}, 32'h0);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        check("t3_b_req",  {31'b0, obs_req}, 32'h1);
        check("t3_b_addr", obs_addr,         32'h100);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        check("t3_c_valid", {31'b0, obs_valid}, 32'h0);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        check("t3_d_valid", {31'b0, obs_valid}, 32'h1);
        pc = 32'h104;
        sb_q.push_back(32'h105);
        sb_q.push_back(32'h109);
        run_core(2, 10, "t3_run");

        // Redirect in the same cycle as a response with two outstanding
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        sb_q.push_back(32'h201);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        check("t4_flush_req",   {31'b0, obs_req},   32'h0);
        check("t4_flush_valid", {31'b0, obs_valid}, 32'h0);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        check("t4_g_req",  {31'b0, obs_req}, 32'h1);
        check("t4_g_addr", obs_addr,         32'h200);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        check("t4_h_valid", {31'b0, obs_valid}, 32'h0);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        check("t4_i_valid", {31'b0, obs_valid}, 32'h1);
        check("t4_sb_empty", sb_q.size(), 0);

        // Grant withheld: request held stable, core stalls
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h0, 1'b0, 1'b1);
            check("t5_req",   {31'b0, obs_req},   32'h1);
            check("t5_addr",  obs_addr,           32'h0);
            check("t5_valid", {31'b0, obs_valid}, 32'h0);
        end
        pc = 32'h0;
        sb_q.push_back(32'h1);
        sb_q.push_back(32'h5);
        run_core(2, 10, "t5_run");
        check("t5_first_gnt", gnt_log[0], 32'h0);

        // Address wrap after redirect near the top of memory
        gnt_log.delete();
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        check("t6_flush_req",   {31'b0, obs_req},   32'h0);
        check("t6_flush_valid", {31'b0, obs_valid}, 32'h0);
        pc = 32'hFFFF_FFF8;
        sb_q.push_back(32'hFFFF_FFF9);
        sb_q.push_back(32'hFFFF_FFFD);
        sb_q.push_back(32'h0000_0001);
        run_core(3, 20, "t6_run");
        check("t6_ngnt_ok", {31'b0, (gnt_log.size() >= 3)}, 32'h1);
        if (gnt_log.size() >= 3) begin
            check("t6_gnt0", gnt_log[0], 32'hFFFF_FFF8);
            check("t6_gnt1", gnt_log[1], 32'hFFFF_FFFC);
            check("t6_gnt2", gnt_log[2], 32'h0000_0000);
        end
        check("t6_pc", pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
